// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply/divide unit for the execute stage.
// Fixed WIDTH-cycle latency; shift-add multiply, restoring divide on magnitudes.
module multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nx;
   logic [CNTW-1:0]    cnt;
   logic               op_div, neg_res, div_zero, div_ovf;
   logic [2*WIDTH-1:0] acc, mcand;
   logic [WIDTH-1:0]   shreg;   // multiplier (mul) or dividend -> quotient (div)
   logic [WIDTH-1:0]   dvs, rem;

   logic               start, last;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] acc_nx, prod;
   logic [WIDTH-1:0]   rem_nx, shreg_nx, quo, res_nx;
   logic [WIDTH:0]     rem_sh, diff, prod_hi;
   logic               exc_nx;

   assign start = (state != RUN) && (ctrl_MULT ^ ctrl_DIV);
   assign last  = (state == RUN) && (cnt == CNTW'(WIDTH - 1));
   assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

   assign busy           = (state == RUN);
   assign data_resultRDY = (state == DONE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? RUN : IDLE;
         RUN:     state_nx = last ? DONE : RUN;
         DONE:    state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // One iteration of whichever operation is in flight, plus final sign/exception fix-up
   always_comb begin
      acc_nx   = acc;
      rem_nx   = rem;
      shreg_nx = shreg;
      rem_sh   = {rem, shreg[WIDTH-1]};
      diff     = rem_sh - {1'b0, dvs};
      if (op_div) begin
         if (!diff[WIDTH]) begin
            rem_nx   = diff[WIDTH-1:0];
            shreg_nx = {shreg[WIDTH-2:0], 1'b1};
         end else begin
            rem_nx   = rem_sh[WIDTH-1:0];
            shreg_nx = {shreg[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nx   = shreg[0] ? acc + mcand : acc;
         shreg_nx = shreg >> 1;
      end

      prod    = neg_res ? -acc_nx : acc_nx;
      prod_hi = prod[2*WIDTH-1:WIDTH-1];
      quo     = shreg_nx;
      if (op_div) begin
         if (div_zero)                 res_nx = '0;
         else if (neg_res && quo != 0) res_nx = -quo;
         else                          res_nx = quo;
         exc_nx = div_zero | div_ovf;
      end else begin
         res_nx = prod[WIDTH-1:0];
         exc_nx = ~((&prod_hi) | ~(|prod_hi));
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt            <= '0;
         op_div         <= 1'b0;
         neg_res        <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         acc            <= '0;
         mcand          <= '0;
         shreg          <= '0;
         dvs            <= '0;
         rem            <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
      end else if (start) begin
         cnt      <= '0;
         op_div   <= ctrl_DIV;
         neg_res  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         div_zero <= (data_operandB == '0);
         div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
         acc      <= '0;
         mcand    <= {{WIDTH{1'b0}}, b_mag};
         shreg    <= a_mag;
         dvs      <= b_mag;
         rem      <= '0;
      end else if (state == RUN) begin
         cnt   <= cnt + 1'b1;
         acc   <= acc_nx;
         mcand <= mcand << 1;
         shreg <= shreg_nx;
         rem   <= rem_nx;
         if (last) begin
            data_result    <= res_nx;
            data_exception <= exc_nx;
         end
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomised self-checking bench for multdiv_unit (WIDTH=32) against a plain
// arithmetic reference model.
module tb_multdiv_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  a = '0, b = '0;
   logic          cm = 1'b0, cd = 1'b0;
   logic [W-1:0]  data_result;
   logic          data_exception, data_resultRDY, busy;

   int total = 0;
   int bad   = 0;

   multdiv_unit #(.WIDTH(W), .CNTW(6)) dut (
      .clock(clk), .reset(rst),
      .data_operandA(a), .data_operandB(b),
      .ctrl_MULT(cm), .ctrl_DIV(cd),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic void ref_op(input bit is_div, input logic [W-1:0] oa, ob,
                                  output logic [W-1:0] r, output logic e);
      longint sa, sb, p;
      sa = longint'($signed(oa));
      sb = longint'($signed(ob));
      if (!is_div) begin
         p = sa * sb;
         r = p[W-1:0];
         e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end else if (ob == 0) begin
         r = '0; e = 1'b1;
      end else if (oa == 32'h8000_0000 && ob == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000; e = 1'b1;
      end else begin
         p = sa / sb;
         r = p[W-1:0];
         e = 1'b0;
      end
   endfunction

   // Starts an op on the next edge and waits (bounded) for the completion strobe.
   task automatic run_op(input bit is_div, input logic [W-1:0] oa, ob,
                         output logic [W-1:0] res, output logic exc, output int lat,
                         output bit ctl_ok, output bit hold_ok);
      logic [W-1:0] prev;
      @(negedge clk);
      a = oa; b = ob; cm = !is_div; cd = is_div;
      @(posedge clk); #1;
      cm = 1'b0; cd = 1'b0; a = $urandom; b = $urandom;
      prev = data_result; lat = 0; ctl_ok = 1'b1; hold_ok = 1'b1;
      res = 'x; exc = 1'bx;
      for (int i = 1; i <= 40; i++) begin
         if (busy !== 1'b1 || data_resultRDY !== 1'b0) ctl_ok = 1'b0;
         if (data_result !== prev) hold_ok = 1'b0;
         @(posedge clk); #1;
         if (data_resultRDY === 1'b1) begin
            lat = i; res = data_result; exc = data_exception;
            if (busy !== 1'b0) ctl_ok = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      total++; if (data_result !== '0) begin bad++; $display("FAIL reset_result got=%h exp=0", data_result); end
      total++; if (data_exception !== 1'b0) begin bad++; $display("FAIL reset_exc got=%b exp=0", data_exception); end
      total++; if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", data_resultRDY); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic check_ops(input string tag, input bit is_div, input logic [W-1:0] va[$], input logic [W-1:0] vb[$]);
      logic [W-1:0] res, er;
      logic         exc, ee;
      int           lat;
      bit           ctl_ok, hold_ok;
      for (int n = 0; n < va.size(); n++) begin
         ref_op(is_div, va[n], vb[n], er, ee);
         run_op(is_div, va[n], vb[n], res, exc, lat, ctl_ok, hold_ok);
         total++; if (res !== er) begin bad++; $display("FAIL %s_result a=%h b=%h got=%h exp=%h", tag, va[n], vb[n], res, er); end
         total++; if (exc !== ee) begin bad++; $display("FAIL %s_exc a=%h b=%h got=%b exp=%b", tag, va[n], vb[n], exc, ee); end
         total++; if (lat !== 32) begin bad++; $display("FAIL %s_latency a=%h b=%h got=%0d exp=32", tag, va[n], vb[n], lat); end
         total++; if (ctl_ok !== 1'b1) begin bad++; $display("FAIL %s_busy_rdy a=%h b=%h got=%b exp=1", tag, va[n], vb[n], ctl_ok); end
         total++; if (hold_ok !== 1'b1) begin bad++; $display("FAIL %s_hold a=%h b=%h got=%b exp=1", tag, va[n], vb[n], hold_ok); end
      end
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return W'($urandom_range(0, 30)) - W'(15);
         2:       return W'(1) << $urandom_range(0, 31);
         default: return $urandom >> $urandom_range(0, 31);
      endcase
   endfunction

   task automatic test_mult;
      logic [W-1:0] va[$], vb[$];
      va = '{32'd7, 32'h4000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_FFFF};
      vb = '{32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'd1, 32'h0000_FFFF};
      for (int n = 0; n < 12; n++) begin va.push_back(rnd_operand()); vb.push_back(rnd_operand()); end
      check_ops("mult", 1'b0, va, vb);
   endtask

   task automatic test_div;
      logic [W-1:0] va[$], vb[$];
      va = '{32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8000_0000, 32'd3, 32'h8000_0000};
      vb = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd1};
      for (int n = 0; n < 12; n++) begin
         va.push_back(rnd_operand());
         vb.push_back(($urandom_range(0, 7) == 0) ? '0 : rnd_operand());
      end
      check_ops("div", 1'b1, va, vb);
   endtask

   task automatic test_ignore_during_run;
      int lat = 0, rdy_cnt = 0;
      logic [W-1:0] res = '0;
      @(negedge clk); a = 32'd3; b = 32'd5; cm = 1'b1;
      @(posedge clk); #1; cm = 1'b0;
      for (int i = 1; i <= 45; i++) begin
         if (i == 5) begin cd = 1'b1; a = 32'd9; b = 32'd3; end
         if (i == 6) cd = 1'b0;
         @(posedge clk); #1;
         if (data_resultRDY === 1'b1) begin
            rdy_cnt++;
            if (lat == 0) begin lat = i; res = data_result; end
         end
      end
      total++; if (res !== 32'd15) begin bad++; $display("FAIL ignore_result got=%h exp=0000000f", res); end
      total++; if (lat !== 32) begin bad++; $display("FAIL ignore_latency got=%0d exp=32", lat); end
      total++; if (rdy_cnt !== 1) begin bad++; $display("FAIL ignore_rdy_count got=%0d exp=1", rdy_cnt); end
   endtask

   task automatic test_both_ctrl;
      @(negedge clk); a = 32'd9; b = 32'd3; cm = 1'b1; cd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++;
         if ({busy, data_resultRDY} !== 2'b00) begin
            bad++; $display("FAIL both_ctrl cycle=%0d got busy,rdy=%b exp=00", i, {busy, data_resultRDY});
         end
      end
      cm = 1'b0; cd = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] va[$], vb[$];
      va = '{32'd6}; vb = '{32'd7};
      check_ops("b2b_mult", 1'b0, va, vb);
      va = '{32'd9}; vb = '{32'd3};
      check_ops("b2b_div", 1'b1, va, vb);
   endtask

   task automatic test_reset_midrun;
      int rdy_cnt = 0, busy_cnt = 0;
      @(negedge clk); a = 32'd6; b = 32'd6; cm = 1'b1;
      @(posedge clk); #1; cm = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrun_busy got=%b exp=0", busy); end
      total++; if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL midrun_rdy got=%b exp=0", data_resultRDY); end
      total++; if (data_result !== '0) begin bad++; $display("FAIL midrun_result got=%h exp=0", data_result); end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (data_resultRDY === 1'b1) rdy_cnt++;
         if (busy === 1'b1) busy_cnt++;
      end
      total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL midrun_no_rdy got=%0d exp=0", rdy_cnt); end
      total++; if (busy_cnt !== 0) begin bad++; $display("FAIL midrun_no_busy got=%0d exp=0", busy_cnt); end
   endtask

   initial begin
      #2;
      test_reset();
      test_mult();
      test_div();
      test_back_to_back();
      test_ignore_during_run();
      test_both_ctrl();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
